// File: rtl/prefix_pkg.sv
// Shared constants, level-count helper and stage record for the prefix carry pipe.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package prefix_pkg;

  localparam int DEFAULT_WIDTH = 8;

  // Number of Kogge-Stone levels (and pipeline registers) for a given operand width.
  function automatic int prefix_levels(input int width);
    return $clog2(width);
  endfunction

  // Per-stage record at the default width: valid flag, group generate/propagate,
  // the untouched per-bit propagate needed for the final sum, and the carry-in.
  typedef struct packed {
    logic                     valid;
    logic [DEFAULT_WIDTH-1:0] g;
    logic [DEFAULT_WIDTH-1:0] p;
    logic [DEFAULT_WIDTH-1:0] prop_orig;
    logic                     cin;
  } stage_t;

endpackage

// File: rtl/prefix_cell.sv
// Kogge-Stone black cell: merges a high group (g_hi, p_hi) with a lower group (g_lo, p_lo).
// Latency: purely combinational.
// Backpressure: none; instantiated inside the registered levels of prefix_carry_pipe.
module prefix_cell (
  input  logic g_hi,
  input  logic p_hi,
  input  logic g_lo,
  input  logic p_lo,
  output logic g,
  output logic p
);

  assign g = g_hi | (p_hi & g_lo);
  assign p = p_hi & p_lo;

endmodule

// File: rtl/prefix_carry_pipe.sv
// Pipelined Kogge-Stone prefix network turning gen/prop/cin into sum/cout; optional ovf port under PREFIX_CARRY_PIPE_OVF_EN.
// Latency: one register per prefix level, so out_valid rises LEVELS cycles after the in_valid cycle (3 for WIDTH=8).
// Backpressure: global stall; every level holds while out_valid & ~out_ready, and in_ready drops with it.
module prefix_carry_pipe
  import prefix_pkg::*;
#(
  parameter  int WIDTH  = DEFAULT_WIDTH,
  localparam int LEVELS = prefix_levels(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] gen,
  input  logic [WIDTH-1:0] prop,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
`ifdef PREFIX_CARRY_PIPE_OVF_EN
  output logic             ovf,
`endif
  output logic             cout
);

  // Stage record at this instance's width (same field layout as prefix_pkg::stage_t).
  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] prop_orig;
    logic             cin;
  } pipe_stage_t;

  logic             advance;
  pipe_stage_t      src [1:LEVELS];   // input side of each level
  pipe_stage_t      stg [1:LEVELS];   // level registers
  logic [WIDTH-1:0] lvl_g [1:LEVELS];
  logic [WIDTH-1:0] lvl_p [1:LEVELS];
  logic [WIDTH-1:0] carries;

  assign advance  = ~out_valid | out_ready;
  assign in_ready = advance;

  // Level 1 sees the input with cin folded into bit 0; later levels see the previous register.
  always_comb begin
    for (int k = 1; k <= LEVELS; k++) begin
      src[k] = '0;
    end
    src[1].valid     = in_valid;
    src[1].g         = gen;
    src[1].g[0]      = gen[0] | (prop[0] & cin);
    src[1].p         = prop;
    src[1].prop_orig = prop;
    src[1].cin       = cin;
    for (int k = 2; k <= LEVELS; k++) begin
      src[k] = stg[k-1];
    end
  end

  // Level k combines each bit with the bit 2^(k-1) below; the low bits pass straight through.
  for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
    localparam int D = 1 << (k - 1);
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      if (i >= D) begin : g_cell
        prefix_cell u_cell (
          .g_hi (src[k].g[i]),
          .p_hi (src[k].p[i]),
          .g_lo (src[k].g[i-D]),
          .p_lo (src[k].p[i-D]),
          .g    (lvl_g[k][i]),
          .p    (lvl_p[k][i])
        );
      end else begin : g_pass
        assign lvl_g[k][i] = src[k].g[i];
        assign lvl_p[k][i] = src[k].p[i];
      end
    end
  end

  // All levels shift together on advance; data loads only behind a valid so bubbles stay quiet.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 1; k <= LEVELS; k++) begin
        stg[k] <= '0;
      end
    end else if (advance) begin
      for (int k = 1; k <= LEVELS; k++) begin
        stg[k].valid <= src[k].valid;
        if (src[k].valid) begin
          stg[k].g         <= lvl_g[k];
          stg[k].p         <= lvl_p[k];
          stg[k].prop_orig <= src[k].prop_orig;
          stg[k].cin       <= src[k].cin;
        end
      end
    end
  end

  // Carry into bit i is the prefix generate of bits i-1..0 (cin already folded in).
  assign carries   = {stg[LEVELS].g[WIDTH-2:0], stg[LEVELS].cin};
  assign sum       = stg[LEVELS].prop_orig ^ carries;
  assign cout      = stg[LEVELS].g[WIDTH-1];
  assign out_valid = stg[LEVELS].valid;

`ifdef PREFIX_CARRY_PIPE_OVF_EN
  // Signed overflow: carry into the sign bit differs from carry out of it.
  assign ovf = carries[WIDTH-1] ^ cout;
`endif

endmodule

// File: tb/tb_prefix_carry_pipe.sv
// Self-checking bench for prefix_carry_pipe: directed cases plus randomized traffic against an arithmetic scoreboard.
// Latency: model tracks each item by counting pipeline advances since acceptance.
// Backpressure: randomized out_ready and occasional mid-stream reset.
module tb_prefix_carry_pipe;
  import prefix_pkg::*;

  localparam int W  = 8;
  localparam int LV = prefix_levels(W);

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    int           stamp;
  } exp_t;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] gen;
  logic [W-1:0] prop;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
`ifdef PREFIX_CARRY_PIPE_OVF_EN
  logic         ovf;
`endif

  logic [W-1:0] x_r;
  logic [W-1:0] y_r;

  exp_t q[$];
  int   adv_cnt;
  bit   armed;
  int   n_tests;
  int   n_fail;

  assign gen  = x_r & y_r;
  assign prop = x_r ^ y_r;

  prefix_carry_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .gen       (gen),
    .prop      (prop),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
`ifdef PREFIX_CARRY_PIPE_OVF_EN
    .ovf       (ovf),
`endif
    .cout      (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: plain (W+1)-bit addition; signed overflow when both operands share a sign the result lacks.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    exp_t         r;
    logic [W:0]   s;
    s       = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    r.sum   = s[W-1:0];
    r.cout  = s[W];
    r.ovf   = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
    r.stamp = 0;
    return r;
  endfunction

  // One clock: check outputs at negedge, then update the scoreboard across the rising edge.
  task automatic tick();
    exp_t e;
    logic exp_vld;
    logic adv;
    logic acc;
    logic emit;
    @(negedge clk);
    exp_vld = (q.size() > 0) && ((adv_cnt - q[0].stamp) == LV);
    if (armed) begin
      chk("out_valid", 32'(out_valid), 32'(exp_vld));
      chk("in_ready", 32'(in_ready), 32'(!exp_vld || out_ready));
      if (exp_vld) begin
        chk("sum", 32'(sum), 32'(q[0].sum));
        chk("cout", 32'(cout), 32'(q[0].cout));
`ifdef PREFIX_CARRY_PIPE_OVF_EN
        chk("ovf", 32'(ovf), 32'(q[0].ovf));
`endif
      end
    end
    adv  = !exp_vld || out_ready;
    acc  = in_valid && adv;
    emit = exp_vld && out_ready;
    e    = model(x_r, y_r, cin);
    @(posedge clk);
    if (rst) begin
      q.delete();
      armed = 1'b1;
    end else if (armed) begin
      if (emit) void'(q.pop_front());
      if (acc) begin
        e.stamp = adv_cnt;
        q.push_back(e);
      end
      if (adv) adv_cnt++;
    end
    #1;
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    in_valid = 1'b1;
    x_r      = a;
    y_r      = b;
    cin      = c;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    adv_cnt   = 0;
    armed     = 1'b0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    x_r       = '0;
    y_r       = '0;
    cin       = 1'b0;

    idle(2);
    rst = 1'b0;
    idle(1);
    chk("rst_sum", 32'(sum), 32'h0);
    chk("rst_cout", 32'(cout), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h1);

    // Basic sum, then the full carry ripple cases and the overflow cases.
    send(8'h5A, 8'h3C, 1'b0);
    idle(5);
    send(8'hFF, 8'h01, 1'b0);
    send(8'hFF, 8'h00, 1'b1);
    send(8'h7F, 8'h01, 1'b0);
    idle(5);

    // Back-to-back throughput.
    send(8'h01, 8'h01, 1'b0);
    send(8'h10, 8'h20, 1'b0);
    send(8'h80, 8'h80, 1'b0);
    send(8'hAA, 8'h55, 1'b0);
    idle(5);

    // Backpressure: three in flight, stall five cycles with input offered, then release.
    send(8'h11, 8'h22, 1'b0);
    send(8'h33, 8'h44, 1'b1);
    send(8'hF0, 8'h0F, 1'b1);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    x_r       = 8'hC3;
    y_r       = 8'h3C;
    idle(5);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    idle(6);

    // Reset with three items in flight; nothing stale may appear afterwards.
    send(8'h01, 8'h02, 1'b0);
    send(8'h03, 8'h04, 1'b0);
    send(8'h05, 8'h06, 1'b0);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    idle(1);
    chk("post_rst_out_valid", 32'(out_valid), 32'h0);
    idle(4);
    send(8'h5A, 8'h3C, 1'b0);
    idle(5);

    // Randomized traffic with random backpressure and rare resets.
    for (int n = 0; n < 600; n++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      x_r       = W'($urandom);
      y_r       = W'($urandom);
      cin       = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 149) == 0);
      tick();
    end
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;

    for (int i = 0; i < 40 && q.size() > 0; i++) tick();
    chk("drain_empty", 32'(q.size()), 32'h0);
    idle(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
